// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the execution controller: debug command codes and FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'd0,
    CMD_STEP  = 2'd1,
    CMD_STOP  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count reflects clear/increment one clock after the edge that sampled them.
// Backpressure: none; clear together with increment loads 1 (the current cycle is counted).
module sat_counter #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [NBITS-1:0] o_count
);

  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  logic [NBITS-1:0] r_count;

  // Clear restarts the count (keeping the current enabled cycle); otherwise count up until all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= i_inc ? ONE : '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: RUN/STEP/STOP/CLEAR commands drive the pipeline enable; HALT retire stops it.
// Latency: command or halt sampled at edge N takes effect in cycle N+1; step_done pulses in N+2.
// Backpressure: o_cmd_ready low only during the single STEP cycle. Cycle counter built when EXEC_CTRL_CYCLE_CNT_EN is defined.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt,
  output logic             o_enable,
  output logic             o_running,
  output logic             o_halted,
  output logic             o_step_done,
  output logic [NBITS-1:0] o_cycle_count
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_step_done;
  logic   w_cmd_acc;
  logic   w_clear;

  assign o_cmd_ready = (r_state != ST_STEP);
  assign w_cmd_acc   = i_cmd_valid & o_cmd_ready;

  // State register; step_done is simply "last cycle was the STEP cycle", so it survives a halt.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_done <= (r_state == ST_STEP);
    end
  end

  // Next state and counter clear; a retiring HALT overrides any command accepted in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    if ((r_state != ST_HALTED) && i_halt) begin
      w_state_nxt = ST_HALTED;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            if (i_cmd == CMD_RUN)        w_state_nxt = ST_RUN;
            else if (i_cmd == CMD_STEP)  w_state_nxt = ST_STEP;
            else if (i_cmd == CMD_CLEAR) w_clear     = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_cmd_acc) begin
            if (i_cmd == CMD_STOP)       w_state_nxt = ST_IDLE;
            else if (i_cmd == CMD_CLEAR) w_clear     = 1'b1;
          end
        end
        ST_STEP: begin
          w_state_nxt = ST_IDLE;
        end
        ST_HALTED: begin
          if (w_cmd_acc && (i_cmd == CMD_CLEAR)) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_enable    = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign o_running   = (r_state == ST_RUN);
  assign o_halted    = (r_state == ST_HALTED);
  assign o_step_done = r_step_done;

`ifdef EXEC_CTRL_CYCLE_CNT_EN
  sat_counter #(
    .NBITS (NBITS)
  ) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_inc   (o_enable),
    .o_count (o_cycle_count)
  );
`else
  logic w_unused_clear;
  assign w_unused_clear = w_clear;
  assign o_cycle_count  = '0;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a rule-level model. Two instances (32-bit and 4-bit counters)
// share all stimulus so saturation is exercised alongside the wide counter.
module tb_exec_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  localparam logic [1:0] C_RUN = 2'd0, C_STEP = 2'd1, C_STOP = 2'd2, C_CLEAR = 2'd3;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 64'd15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic halt = 1'b0;

  logic rdy_a, en_a, run_a, hlt_a, sd_a;
  logic rdy_b, en_b, run_b, hlt_b, sd_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_ctrl #(.NBITS(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld), .i_cmd(cmd), .o_cmd_ready(rdy_a),
    .i_halt(halt), .o_enable(en_a), .o_running(run_a), .o_halted(hlt_a),
    .o_step_done(sd_a), .o_cycle_count(cnt_a)
  );

  exec_ctrl #(.NBITS(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld), .i_cmd(cmd), .o_cmd_ready(rdy_b),
    .i_halt(halt), .o_enable(en_b), .o_running(run_b), .o_halted(hlt_b),
    .o_step_done(sd_b), .o_cycle_count(cnt_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Counter value the build is expected to show (tied to zero when the counter is compiled out).
  function automatic longint exp_cnt(input longint v);
`ifdef EXEC_CTRL_CYCLE_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic longint sat_next(input longint v, input bit en, input bit clr, input longint maxv);
    longint r;
    r = clr ? 0 : v;
    if (en && r < maxv) r = r + 1;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int     m_mode = M_IDLE;
  bit     m_sd   = 1'b0;
  longint m_c32  = 0;
  longint m_c4   = 0;
  int     m_next;
  bit     m_clr, m_en, m_acc;

  // Rule table: halt wins outside HALTED, STEP lasts one cycle, otherwise apply the accepted command.
  always_comb begin
    m_en   = (m_mode == M_RUN) || (m_mode == M_STEP);
    m_acc  = vld && (m_mode != M_STEP);
    m_next = m_mode;
    m_clr  = 1'b0;
    if (m_mode != M_HALT && halt) begin
      m_next = M_HALT;
    end else if (m_mode == M_STEP) begin
      m_next = M_IDLE;
    end else if (m_acc) begin
      if (cmd == C_CLEAR) begin
        m_clr = 1'b1;
        if (m_mode == M_HALT) m_next = M_IDLE;
      end else if (m_mode == M_IDLE && cmd == C_RUN) begin
        m_next = M_RUN;
      end else if (m_mode == M_IDLE && cmd == C_STEP) begin
        m_next = M_STEP;
      end else if (m_mode == M_RUN && cmd == C_STOP) begin
        m_next = M_IDLE;
      end
    end
  end

  // Model state advance, mirroring the asynchronous reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE;
      m_sd   <= 1'b0;
      m_c32  <= 0;
      m_c4   <= 0;
    end else begin
      m_mode <= m_next;
      m_sd   <= (m_mode == M_STEP);
      m_c32  <= sat_next(m_c32, m_en, m_clr, MAX32);
      m_c4   <= sat_next(m_c4, m_en, m_clr, MAX4);
    end
  end

  // Every-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("enable",    longint'(en_a),  longint'((m_mode == M_RUN) || (m_mode == M_STEP)));
    chk("running",   longint'(run_a), longint'(m_mode == M_RUN));
    chk("halted",    longint'(hlt_a), longint'(m_mode == M_HALT));
    chk("cmd_ready", longint'(rdy_a), longint'(m_mode != M_STEP));
    chk("step_done", longint'(sd_a),  longint'(m_sd));
    chk("count32",   longint'(cnt_a), exp_cnt(m_c32));
    chk("enable4",   longint'(en_b),  longint'((m_mode == M_RUN) || (m_mode == M_STEP)));
    chk("halted4",   longint'(hlt_b), longint'(m_mode == M_HALT));
    chk("count4",    longint'(cnt_b), exp_cnt(m_c4));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    vld = 1'b1;
    cmd = c;
    tick();
    vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_enable", longint'(en_a), 0);
    chk("rst_ready",  longint'(rdy_a), 1);
    chk("rst_count",  longint'(cnt_a), 0);
    rst = 1'b0;

    // single step twice
    send(C_STEP);
    chk("step_en_hi", longint'(en_a), 1);
    chk("step_rdy_lo", longint'(rdy_a), 0);
    tick();
    chk("step_en_lo", longint'(en_a), 0);
    chk("step_done_hi", longint'(sd_a), 1);
    chk("step_cnt1", longint'(cnt_a), exp_cnt(1));
    tick();
    chk("step_done_lo", longint'(sd_a), 0);
    send(C_STEP);
    tick();
    chk("step_cnt2", longint'(cnt_a), exp_cnt(2));

    // run ten enabled cycles then stop
    send(C_CLEAR);
    chk("clr_idle_cnt", longint'(cnt_a), 0);
    send(C_RUN);
    repeat (9) tick();
    send(C_STOP);
    chk("stop_en", longint'(en_a), 0);
    chk("stop_running", longint'(run_a), 0);
    chk("stop_cnt10", longint'(cnt_a), exp_cnt(10));

    // halt together with STOP: halt wins, RUN ignored, CLEAR recovers
    send(C_RUN);
    tick();
    tick();
    halt = 1'b1;
    vld  = 1'b1;
    cmd  = C_STOP;
    tick();
    halt = 1'b0;
    vld  = 1'b0;
    chk("halt_halted", longint'(hlt_a), 1);
    chk("halt_en", longint'(en_a), 0);
    send(C_RUN);
    tick();
    chk("halt_run_ign", longint'(hlt_a), 1);
    chk("halt_run_en", longint'(en_a), 0);
    send(C_CLEAR);
    chk("halt_clr_state", longint'(hlt_a), 0);
    chk("halt_clr_cnt", longint'(cnt_a), 0);

    // 4-bit saturation and CLEAR while running
    send(C_RUN);
    repeat (20) tick();
    chk("sat_cnt32", longint'(cnt_a), exp_cnt(20));
    chk("sat_cnt4", longint'(cnt_b), exp_cnt(15));
    send(C_CLEAR);
    chk("runclr_cnt32", longint'(cnt_a), exp_cnt(1));
    chk("runclr_cnt4", longint'(cnt_b), exp_cnt(1));
    chk("runclr_running", longint'(run_a), 1);
    send(C_STOP);

    // asynchronous reset mid-run
    send(C_CLEAR);
    send(C_RUN);
    repeat (5) tick();
    chk("pre_rst_cnt5", longint'(cnt_a), exp_cnt(5));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en", longint'(en_a), 0);
    chk("arst_running", longint'(run_a), 0);
    chk("arst_cnt", longint'(cnt_a), 0);
    chk("arst_ready", longint'(rdy_a), 1);
    tick();
    rst = 1'b0;
    send(C_RUN);
    repeat (3) tick();
    chk("post_rst_cnt3", longint'(cnt_a), exp_cnt(3));
    chk("post_rst_run", longint'(run_a), 1);
    send(C_STOP);

    // randomized traffic, checked by the every-cycle compare process
    for (int i = 0; i < 4000; i++) begin
      vld  = ($urandom_range(0, 99) < 30);
      cmd  = 2'($urandom_range(0, 3));
      halt = ($urandom_range(0, 49) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      tick();
    end
    vld  = 1'b0;
    halt = 1'b0;
    rst  = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
